clk_gate_ctrl: RTL
==================

# clk_gate_ctrl

Idle-detect clock-gating controller that produces the enable for one `icg` instance. It watches a clock domain's activity and counts idle cycles. It runs a sleep handshake so the domain can quiesce, then drops the ICG enable. On a wake request it re-enables the clock and acknowledges once the clock has been stable for a programmed number of cycles. It sits in the free-running clock domain beside the `icg` it controls; `icg_en` connects directly to the `icg` `en` pin.

## Interface
- `IDLE_CYCLES`, default 16: consecutive idle cycles required before sleep is requested; must be ≥1.
- `WAKE_CYCLES`, default 2: cycles the clock runs after ungating before the domain is reported awake; must be ≥1.
- `CNT_W`, default `$clog2(max(IDLE_CYCLES,WAKE_CYCLES))+1`: down-counter width; derived, do not override.

- `clk` input 1: free-running clock, ungated side of the `icg`.
- `rst_n` input 1: asynchronous, active-low reset.
- `busy` input 1: domain activity, synchronous to `clk`; high means the domain must not be gated.
- `force_on` input 1: CSR override; high keeps the clock on and aborts any sleep sequence.
- `wake_req` input 1: four-phase wake request from a requester outside the domain.
- `wake_ack` output 1: wake acknowledge, registered.
- `sleep_req` output 1: asks the domain to drain, registered.
- `sleep_ack` input 1: domain quiesced, synchronous to `clk`.
- `icg_en` output 1: drives the `icg` `en` pin, registered.
- `gated` output 1: status, high while the clock is gated.

## Operation
- All outputs are registered. Reset values: `icg_en`=1, `sleep_req`=0, `wake_ack`=0, `gated`=0. The state is RUN and the counter is 0.
- The abort condition `hold` is `busy | force_on | wake_req`.
- States and transitions (evaluated each `clk` edge):
  - RUN (`icg_en`=1): if `!hold`, go to IDLE and load cnt=IDLE_CYCLES-1.
  - IDLE (`icg_en`=1):
    - if `hold`, go to RUN;
    - else if cnt==0, go to DRAIN;
    - else decrement cnt.
  - DRAIN (`icg_en`=1, `sleep_req`=1):
    - if `hold`, go to RUN and drop `sleep_req`;
    - else if `sleep_ack`, go to GATED.
  - GATED (`icg_en`=0, `gated`=1, `sleep_req`=1): if `force_on | wake_req`, go to WAKE and load cnt=WAKE_CYCLES-1. `busy` is ignored in this state because the domain is stopped.
  - WAKE (`icg_en`=1, `sleep_req`=0):
    - if cnt==0, go to RUN;
    - else decrement cnt.
    - Inputs are not sampled.
- `wake_ack` is the registered value of `wake_req & (next state ∈ {RUN})`. It falls the cycle after `wake_req` falls.
- Priority on simultaneous events in DRAIN: `hold` beats `sleep_ack`. A wake arriving in the same cycle as `sleep_ack` returns to RUN, and the clock never stops.
- `sleep_ack` outside DRAIN is ignored.
- `rst_n` asserted mid-sequence (including GATED) forces the reset values immediately. The clock is on while `rst_n` is low.

## Timing
- Idle to sleep request: `busy` is low at edge t with no other `hold`. Then:
  - IDLE is entered at t+1;
  - DRAIN and `sleep_req`=1 follow at t+1+IDLE_CYCLES.
- `sleep_ack` sampled high at edge s: GATED at s+1, `icg_en`=0 at s+1. The `icg` stops the gated clock from the next low phase.
- Wake: `wake_req` sampled high in GATED at edge w. Then:
  - `icg_en`=1 at w+1;
  - RUN is entered at w+WAKE_CYCLES+1;
  - `wake_ack`=1 at the same edge.
- Wake while already RUN/IDLE/DRAIN: `wake_ack`=1 one edge after `wake_req` is sampled.
- Steady-state gate/ungate round trip: IDLE_CYCLES+WAKE_CYCLES+3 cycles minimum, with `sleep_ack` immediate.

## Structure
- Package `clk_gate_pkg` holds:
  - `typedef enum logic [2:0] {CG_RUN, CG_IDLE, CG_DRAIN, CG_GATED, CG_WAKE} cg_state_e`;
  - a default-parameter constant for IDLE_CYCLES and WAKE_CYCLES.
- A single shared down-counter is used; IDLE and WAKE never overlap.
- There is no sub-module. The `icg` is instantiated by the integrator next to this block, not inside it.
- Parameter assertions: IDLE_CYCLES≥1 and WAKE_CYCLES≥1.

## Test plan
- IDLE_CYCLES=4, WAKE_CYCLES=2. Reset with all inputs low, then release: `icg_en`=1 during reset, DRAIN reached 5 edges after release, and `sleep_req`=1.
- In DRAIN, pulse `sleep_ack`: `icg_en`=0 and `gated`=1 next edge. Then raise `wake_req` and hold it until `wake_ack`: `icg_en`=1 after 1 edge and `wake_ack`=1 after 3 edges. Drop `wake_req`: `wake_ack`=0 one edge later.
- Raise `busy` for 1 cycle when cnt=1 in IDLE: the FSM returns to RUN, a full 4-cycle idle count restarts, and `sleep_req` never rises early.
- Assert `sleep_ack` and `wake_req` in the same DRAIN cycle: the next state is RUN, `icg_en` stays 1 throughout, `gated` stays 0, and `wake_ack`=1 one edge later.
- Hold `force_on`=1 for 100 cycles with `busy`=0: `icg_en`=1 and `sleep_req`=0 throughout. Deassert it: DRAIN after 5 edges.
- Assert `rst_n` low while GATED: `icg_en`=1, `gated`=0 and `sleep_req`=0 asynchronously, before the next `clk` edge.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared types and defaults for the idle-detect clock-gating controller.
package clk_gate_pkg;

  // Controller states; IDLE and WAKE share the single down-counter.
  typedef enum logic [2:0] {
    CG_RUN,
    CG_IDLE,
    CG_DRAIN,
    CG_GATED,
    CG_WAKE
  } cg_state_e;

  // Default idle and wake windows, in clk cycles.
  localparam int unsigned CG_IDLE_CYCLES_DEF = 16;
  localparam int unsigned CG_WAKE_CYCLES_DEF = 2;

endpackage : clk_gate_pkg

// File: rtl/clk_gate_ctrl.sv
// Idle-detect clock-gating controller: counts idle cycles, runs a sleep
// handshake with the domain, drops the ICG enable, and re-enables it on a
// wake request, acknowledging once the clock has run for WAKE_CYCLES.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = CG_IDLE_CYCLES_DEF,
  parameter int unsigned WAKE_CYCLES = CG_WAKE_CYCLES_DEF,
  parameter int unsigned CNT_W =
    $clog2((IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic force_on,
  input  logic wake_req,
  output logic wake_ack,
  output logic sleep_req,
  input  logic sleep_ack,
  output logic icg_en,
  output logic gated
);

  // Both windows must be at least one cycle long.
  if (IDLE_CYCLES < 1) begin : g_bad_idle
    $error("clk_gate_ctrl: IDLE_CYCLES must be >= 1");
  end
  if (WAKE_CYCLES < 1) begin : g_bad_wake
    $error("clk_gate_ctrl: WAKE_CYCLES must be >= 1");
  end

  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

  cg_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             icg_en_q, icg_en_d;
  logic             sleep_req_q, sleep_req_d;
  logic             wake_ack_q, wake_ack_d;
  logic             gated_q, gated_d;

  // Any activity, override or wake request aborts the sleep sequence.
  logic hold;
  assign hold = busy | force_on | wake_req;

  // State, counter and registered outputs; reset leaves the clock running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CG_RUN;
      cnt_q       <= '0;
      icg_en_q    <= 1'b1;
      sleep_req_q <= 1'b0;
      wake_ack_q  <= 1'b0;
      gated_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every flop samples the pre-edge values of
      // its inputs, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      icg_en_q    <= icg_en_d;
      sleep_req_q <= sleep_req_d;
      wake_ack_q  <= wake_ack_d;
      gated_q     <= gated_d;
    end
  end

  // Next-state and shared down-counter update.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; a missing
    // assignment here would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CG_RUN: begin
        if (!hold) begin
          state_d = CG_IDLE;
          cnt_d   = IDLE_LOAD;
        end
      end
      CG_IDLE: begin
        if (hold) begin
          state_d = CG_RUN;
        end else if (cnt_q == '0) begin
          state_d = CG_DRAIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CG_DRAIN: begin
        // An abort wins over a simultaneous quiesce acknowledge.
        if (hold) begin
          state_d = CG_RUN;
        end else if (sleep_ack) begin
          state_d = CG_GATED;
        end
      end
      CG_GATED: begin
        // busy is meaningless while the domain clock is stopped.
        if (force_on | wake_req) begin
          state_d = CG_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      CG_WAKE: begin
        // Let the clock settle for the full window regardless of inputs.
        if (cnt_q == '0) begin
          state_d = CG_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = CG_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values decoded from the next state so the outputs are registered
  // yet change on the same edge as the state.
  always_comb begin
    icg_en_d    = (state_d != CG_GATED);
    gated_d     = (state_d == CG_GATED);
    sleep_req_d = (state_d == CG_DRAIN) || (state_d == CG_GATED);
    wake_ack_d  = wake_req && (state_d == CG_RUN);
  end

  assign icg_en    = icg_en_q;
  assign sleep_req = sleep_req_q;
  assign wake_ack  = wake_ack_q;
  assign gated     = gated_q;

endmodule : clk_gate_ctrl
